// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types for the data memory unit:
//   dmem_size_e   - access size encoding carried on req_size
//   dmem_state_e  - request FSM states (IDLE, WAIT, RESP)
//   CNT_W         - width of the latency down-counter
//   size_to_mask  - byte-lane enables for an access size, relative to addr
//   is_misaligned - natural-alignment test used when the misalign trap is built
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_WORD3 = 2'b11   // alternate word encoding
    } dmem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Holds LATENCY-2 for the largest legal LATENCY of 15.
    localparam int CNT_W = 4;

    function automatic logic [3:0] size_to_mask(input dmem_size_e size);
        case (size)
            SIZE_BYTE: size_to_mask = 4'b0001;
            SIZE_HALF: size_to_mask = 4'b0011;
            default:   size_to_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// ----------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter. Takes the four bytes starting at the access
// address (little-endian, byte 0 in bits 7:0), keeps the bytes the access size
// covers and sign- or zero-extends the result to the bus width.
// Ports:
//   raw_word    in  32          bytes addr+0..addr+3
//   size        in  dmem_size_e access size
//   is_unsigned in  1           1 = zero-extend, 0 = sign-extend
//   load_data   out DATA_WIDTH  formatted load result
// ----------------------------------------------------------------------------
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           raw_word,
    input  dmem_size_e            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic fill;

    // Fill the whole bus with the extension bit first, then overlay the
    // selected low bytes; this avoids zero-width replications when the
    // access is as wide as the bus.
    always_comb begin
        fill      = 1'b0;
        load_data = '0;
        case (size)
            SIZE_BYTE: begin
                fill           = raw_word[7] & ~is_unsigned;
                load_data      = {DATA_WIDTH{fill}};
                load_data[7:0] = raw_word[7:0];
            end
            SIZE_HALF: begin
                fill            = raw_word[15] & ~is_unsigned;
                load_data       = {DATA_WIDTH{fill}};
                load_data[15:0] = raw_word[15:0];
            end
            default: begin
                fill            = raw_word[31] & ~is_unsigned;
                load_data       = {DATA_WIDTH{fill}};
                load_data[31:0] = raw_word;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// ----------------------------------------------------------------------------
// data_mem_unit
// Byte-addressed data memory with a fixed-latency request/response handshake
// and one request outstanding at a time.
// Optional build macro: DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses
// are not performed and respond with resp_err=1, resp_rdata=0. Without it,
// misaligned accesses proceed byte by byte and resp_err stays 0.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_addr              byte address, low ADDR_WIDTH bits decoded
//   req_wdata             store data (low 32 bits used)
//   req_size              00 byte, 01 half, 10/11 word
//   req_unsigned          zero-extend loads when 1
//   resp_valid            one-cycle response strobe, LATENCY cycles after accept
//   resp_rdata, resp_err  response payload, held until the next response
// ----------------------------------------------------------------------------
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 17,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int               DEPTH    = 1 << ADDR_WIDTH;
    localparam bit               LIVE     = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    logic [7:0] mem [DEPTH];

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    dmem_size_e            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  accept;
    logic                  commit;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_wdata;
    dmem_size_e            c_size;
    logic                  c_unsigned;
    logic                  c_misaligned;
    logic [3:0]            c_mask;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] byte_addr [4];
    logic [31:0]           raw_word;
    logic [DATA_WIDTH-1:0] load_data;

    // Address bits above the decoded range and store bits above 32 are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{req_addr, req_wdata};

    assign req_ready = (state_q == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the memory access happens on the accept edge itself, so
    // the live request drives the array; otherwise the latched copy does and
    // the access fires on the WAIT cycle whose counter has run out.
    assign c_we       = LIVE ? req_we                    : we_q;
    assign c_addr     = LIVE ? req_addr[ADDR_WIDTH-1:0]  : addr_q;
    assign c_wdata    = LIVE ? req_wdata[31:0]           : wdata_q;
    assign c_size     = LIVE ? dmem_size_e'(req_size)    : size_q;
    assign c_unsigned = LIVE ? req_unsigned              : unsigned_q;
    assign commit     = LIVE ? accept : ((state_q == ST_WAIT) && (cnt_q == '0));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign c_misaligned = is_misaligned(c_size, c_addr[1:0]);
`else
    assign c_misaligned = 1'b0;
`endif

    assign c_mask   = size_to_mask(c_size);
    assign do_write = commit && c_we && !c_misaligned;

    // Each lane addresses its own byte so accesses crossing the top of the
    // array wrap around to byte 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_addr[gi]       = c_addr + ADDR_WIDTH'(gi);
            assign raw_word[8*gi +: 8] = mem[byte_addr[gi]];
        end
    endgenerate

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (c_mask[k]) begin
                    mem[byte_addr[k]] <= c_wdata[8*k +: 8];
                end
            end
        end
    end

    dmem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .raw_word    (raw_word),
        .size        (c_size),
        .is_unsigned (c_unsigned),
        .load_data   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d       = req_we;
                    addr_d     = req_addr[ADDR_WIDTH-1:0];
                    wdata_d    = req_wdata[31:0];
                    size_d     = dmem_size_e'(req_size);
                    unsigned_d = req_unsigned;
                    if (LIVE) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The response payload is captured on the same edge that enters RESP.
        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = c_misaligned;
            resp_rdata_d = (c_we || c_misaligned) ? '0 : load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_data_mem_unit
// Randomized scoreboard bench for data_mem_unit. A driver issues requests and
// pushes the reference model's expected response into a queue; a monitor pops
// and compares on every resp_valid. Two extra instances (LATENCY 1 and 4) are
// used for handshake timing. Honors DMEM_MISALIGN_TRAP_EN when defined.
// ----------------------------------------------------------------------------
module tb_data_mem_unit;

    localparam int DW    = 32;
    localparam int AW    = 17;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   resp_rdata;

    logic          v1 = 1'b0, v4 = 1'b0;
    logic          r1, r4, rv1, rv4, e1, e4;
    logic [31:0]   rd1, rd4;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_req_cyc = 0;
    int            n_resp = 0;
    exp_t          exp_q[$];
    logic [31:0]   last_rdata = '0;
    logic          last_err = 1'b0;
    logic [7:0]    ref_mem [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_FILE("")) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err));

    data_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1), .INIT_FILE("")) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(e1));

    data_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(4), .INIT_FILE("")) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(r4),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(rv4), .resp_rdata(rd4), .resp_err(e4));

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: memory as a plain byte array, values assembled
    // little-endian with arithmetic and sign handled by subtracting 2^bits.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rd, output logic err);
        int     nb;
        int     a;
        longint v;
        bit     mis;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a   = int'(addr & 32'(DEPTH - 1));
        mis = TRAP && ((a % nb) != 0);
        rd  = '0;
        err = mis;
        if (!mis) begin
            if (we) begin
                for (int k = 0; k < nb; k++) ref_mem[(a + k) % DEPTH] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < nb; k++) v = v + (longint'(ref_mem[(a + k) % DEPTH]) << (8 * k));
                if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
                rd = v[31:0];
            end
        end
    endfunction

    // Monitor: every response is popped from the scoreboard and compared;
    // between responses the payload must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_rdata = '0;
            last_err   = 1'b0;
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp at cycle %0d: resp_valid=1 rdata=0x%08h, expected no response", cyc, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                n_resp++;
                $display("resp %0d cycle %0d: rdata=0x%08h err=%0b (exp 0x%08h err=%0b)",
                         n_resp, cyc, resp_rdata, resp_err, e.rdata, e.err);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_latency_cycle", 32'(cyc), 32'(e.due));
                last_rdata = e.rdata;
                last_err   = e.err;
            end
        end else begin
            check("rdata_hold", resp_rdata, last_rdata);
            check("err_hold", 32'(resp_err), 32'(last_err));
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns,
                         input bit use_exp, input logic [31:0] exp_val, input bit b2b);
        int          waited;
        exp_t        e;
        logic [31:0] rd;
        logic        err;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout at cycle %0d: req_ready=0 after %0d cycles, expected 1", cyc, waited);
            req_valid = 1'b0;
            return;
        end
        // req_ready is high for the coming edge, so this request is accepted there.
        if (b2b) check("b2b_interval", 32'(cyc - last_req_cyc), 32'(LAT + 1));
        last_req_cyc = cyc;
        model(we, addr, wd, size, uns, rd, err);
        e.rdata = use_exp ? exp_val : rd;
        e.err   = err;
        e.due   = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        // Garbage on an unaccepted request must be ignored.
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [16:0] a;
        r = int'($urandom_range(0, 3));
        case (r)
            0:       a = 17'($urandom_range(0, 16'h3C));
            1:       a = 17'(32'h100 + $urandom_range(0, 12));
            2:       a = 17'(32'h200 + $urandom_range(0, 12));
            default: a = 17'(32'h1FFF0 + $urandom_range(0, 15));
        endcase
        return ($urandom & 32'hFFFE_0000) | 32'(a);
    endfunction

    task automatic rand_issue(input bit b2b);
        issue(1'($urandom), rand_addr(), $urandom, 2'($urandom), 1'($urandom), 1'b0, '0, b2b);
    endtask

    // Single request into a fixed-latency instance; checks strobe timing and
    // that req_ready stays low through RESP.
    task automatic lat_test(input int lat);
        @(negedge clk);
        req_we = 1'b0; req_addr = '0; req_size = 2'd2; req_unsigned = 1'b0;
        if (lat == 1) v1 = 1'b1; else v4 = 1'b1;
        check("lat_ready_idle", 32'((lat == 1) ? r1 : r4), 32'd1);
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            check("lat_resp_valid", 32'((lat == 1) ? rv1 : rv4), 32'(c == lat));
            check("lat_req_ready", 32'((lat == 1) ? r1 : r4), 32'(c == lat + 1));
            if (c <= lat) @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] wrap_exp [4];
        logic [31:0] wrap_addr [4];
        bit          held;
        logic [31:0] rd_tmp;
        logic        err_tmp;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready), 32'd1);

        lat_test(1);
        lat_test(4);

        // Fill the address windows used by random traffic (held valid).
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0, '0, i > 0);
        for (int i = 0; i < 4; i++)  issue(1'b1, 32'h100 + 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++)  issue(1'b1, 32'h200 + 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++)  issue(1'b1, 32'h1FFF0 + 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0, '0, 1'b1);

        // Byte sign/zero extension from a stored word
        issue(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, '0, 1'b1);
        issue(1'b0, 32'h103, '0, 2'd0, 1'b0, 1'b1, 32'hFFFFFFDE, 1'b1);
        issue(1'b0, 32'h103, '0, 2'd0, 1'b1, 1'b1, 32'h000000DE, 1'b1);
        // Half store leaves the neighbouring half intact
        issue(1'b1, 32'h200, 32'h12345678, 2'd2, 1'b0, 1'b0, '0, 1'b1);
        issue(1'b1, 32'h202, 32'h00008001, 2'd1, 1'b0, 1'b0, '0, 1'b1);
        issue(1'b0, 32'h202, '0, 2'd1, 1'b0, 1'b1, 32'hFFFF8001, 1'b1);
        issue(1'b0, 32'h200, '0, 2'd2, 1'b0, 1'b1, 32'h80015678, 1'b1);
        // Word store straddling the top of memory
        issue(1'b1, 32'h1FFFE, 32'hA1B2C3D4, 2'd2, 1'b0, 1'b0, '0, 1'b1);
        wrap_addr[0] = 32'h1FFFE; wrap_addr[1] = 32'h1FFFF; wrap_addr[2] = 32'h0; wrap_addr[3] = 32'h1;
        wrap_exp[0] = 32'hD4; wrap_exp[1] = 32'hC3; wrap_exp[2] = 32'hB2; wrap_exp[3] = 32'hA1;
        for (int k = 0; k < 4; k++) issue(1'b0, wrap_addr[k], '0, 2'd0, 1'b1, !TRAP, wrap_exp[k], 1'b1);

        // Continuous valid: one accept every LAT+1 cycles
        for (int i = 0; i < 8; i++) rand_issue(1'b1);
        drain();

        // Reset in the middle of a store's WAIT cycle
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h5A5A_0F0F; req_size = 2'd2; req_valid = 1'b1;
        model(1'b0, 32'h10, '0, 2'd2, 1'b0, rd_tmp, err_tmp);
        req_wdata = ~rd_tmp;
        for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
        check("rst_mid_accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_resp_rdata", resp_rdata, 32'd0);
        check("rst_mid_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        check("rst_mid_resp_valid_hold", 32'(resp_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_release_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h10, '0, 2'd2, 1'b0, 1'b1, rd_tmp, 1'b0);
        drain();

        // Random mix with held and gapped valid
        held = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rand_issue(held);
            if ($urandom_range(0, 1) == 1) begin
                held = 1'b1;
            end else begin
                idle(int'($urandom_range(0, 3)));
                held = 1'b0;
            end
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
